// File: rtl/shift_pkg.sv
// Shared encodings for the counted shift register: shift modes and FSM states.
package shift_pkg;

  localparam logic [1:0] SH_LSR = 2'b00;
  localparam logic [1:0] SH_ASR = 2'b01;
  localparam logic [1:0] SH_LSL = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_step_unit.sv
// One bit-step of the shift register: next value and the bit shifted out.
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] value,
  input  logic             serial_in,
  output logic [WIDTH-1:0] next_value,
  output logic             bit_out
);

  always_comb begin
    next_value = value;
    bit_out    = value[0];
    case (mode)
      SH_LSR: next_value = {serial_in, value[WIDTH-1:1]};
      SH_ASR: next_value = {value[WIDTH-1], value[WIDTH-1:1]};
      SH_LSL: begin
        next_value = {value[WIDTH-2:0], serial_in};
        bit_out    = value[WIDTH-1];
      end
      SH_ROR: next_value = {value[0], value[WIDTH-1:1]};
      default: next_value = value;
    endcase
  end

endmodule

// File: rtl/shiftreg_seq_param.sv
// Parametrised shift register with parallel load, single steps and counted
// shifts (one bit per clock) under a start/busy/done handshake.
module shiftreg_seq_param
  import shift_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] ins,
  input  logic             shift,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] outs,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output shift_state_e     fsm_state
);

  // Handshake: start is taken only in IDLE; busy is high for exactly `amount`
  // cycles from the cycle after start, then done pulses for one cycle with the
  // result already on outs. A load while busy aborts without a done pulse.

  shift_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       mode_q;

  logic [1:0]       step_mode;
  logic [WIDTH-1:0] step_value;
  logic             step_bit;

  // Single steps follow the live mode; counted shifts use the latched one.
  assign step_mode = (state_q == S_SHIFT) ? mode_q : mode;
  assign fsm_state = state_q;

  shift_step_unit #(.WIDTH(WIDTH)) u_step (
    .mode       (step_mode),
    .value      (outs),
    .serial_in  (serial_in),
    .next_value (step_value),
    .bit_out    (step_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mode_q     <= SH_LSR;
      outs       <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load) begin
            outs <= ins;
          end else if (start) begin
            if (amount == '0) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end else begin
              cnt_q   <= amount;
              mode_q  <= mode;
              busy    <= 1'b1;
              state_q <= S_SHIFT;
            end
          end else if (shift) begin
            outs       <= step_value;
            serial_out <= step_bit;
          end
        end

        S_SHIFT: begin
          if (load) begin
            outs    <= ins;
            cnt_q   <= '0;
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            outs       <= step_value;
            serial_out <= step_bit;
            cnt_q      <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
